a78_clk_enables: RTL and testbench
==================================

# a78_clk_enables

Clock-enable and reset sequencer fed by the system PLL. It runs on the 57.272728 MHz PLL output and derives single-cycle enables for the 14.318 MHz, 7.159 MHz and CPU domains. The CPU enables stretch between 1.79 MHz (fast) and 1.19 MHz (slow, for TIA/RIOT access). It also holds the system in reset until the PLL `locked` output has been stable, and supports cycle-boundary pause. All core logic downstream uses these enables instead of separate clocks.

## Interface
Parameters:
- `LOCK_DELAY`, 1024: `clk_sys` cycles that synchronized lock must stay high before `sys_reset_n` releases.
- `FAST_TICKS`, 4: 7M ticks per fast CPU cycle.
- `SLOW_TICKS`, 6: 7M ticks per slow CPU cycle.

Ports:
- `clk_sys` in 1: 57.272728 MHz; the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `pll_locked` in 1: asynchronous PLL lock; 2-flop synchronized internally.
- `slow_req` in 1: current CPU access targets TIA/RIOT.
- `pause` in 1: freeze the CPU at the next cycle boundary.
- `sys_reset_n` out 1: registered system reset, active-low.
- `ce_14` out 1: 14.318 MHz enable, 1-in-4 pulse.
- `ce_7` out 1: 7.159 MHz enable, 1-in-8 pulse.
- `cpu_phi1` out 1: CPU cycle-start enable.
- `cpu_phi2` out 1: CPU mid-cycle enable (data phase).
- `cpu_slow` out 1: length of the current CPU cycle (1 = SLOW_TICKS).

## Operation
- **Lock sequencing**
  - `lock_s` = `pll_locked` after 2 flops.
  - `lock_cnt` counts up while `lock_s`=1 and saturates at LOCK_DELAY.
  - `lock_cnt` clears the cycle `lock_s`=0.
  - `sys_reset_n` <= (`lock_cnt` == LOCK_DELAY).
- **Run gating:** run = `sys_reset_n`. While run=0:
  - `div8`, `tick`, `len` and `cpu_slow` are held at 0 (`len` at FAST).
  - All `ce_*` and `cpu_*` outputs are 0.
- **Base divider:** 3-bit `div8` increments every run cycle and wraps 7->0. All outputs are registered from the current state:
  - `ce_14` = (`div8[1:0]`==3).
  - `ce_7` = (`div8`==7).
- **CPU divider:** `tick` counts `ce_7` pulses, range 0..`len`-1.
  - `len` is latched as `slow_req` ? SLOW_TICKS : FAST_TICKS on the `ce_7` where `tick`==0.
  - `cpu_slow` mirrors `len`.
  - `cpu_phi2` pulses with `ce_7` when `tick`==`len`/2-1.
  - `cpu_phi1` pulses with `ce_7` when `tick`==`len`-1; `tick` wraps to 0 on the same edge.
- **Pause**
  - Sampled only on the boundary `ce_7` (`tick`==`len`-1).
  - If `pause`=1: no `cpu_phi1`, and `tick` holds at `len`-1.
  - Re-evaluated at every subsequent `ce_7`. The first `ce_7` with `pause`=0 issues `cpu_phi1` and wraps.
  - `ce_14`/`ce_7` never stop for pause.
- **Loss of lock mid-operation**
  - `sys_reset_n` falls 3 cycles after `pll_locked` falls (2 sync + 1 register).
  - Counters clear and enables stop the next cycle, even mid CPU cycle.
- **`rst_n`=0:** every register clears, including `lock_cnt` and both sync flops.

## Timing
- Reset values: all outputs 0; `len`=FAST_TICKS.
- From `rst_n` release with `pll_locked`=1: `sys_reset_n` rises at cycle 2+LOCK_DELAY+1.
- First `ce_14` on the 4th run cycle; first `ce_7` on the 8th run cycle.
- Enables are exactly one `clk_sys` cycle wide. `ce_7` always coincides with a `ce_14`.
- Fast CPU cycle = 32 `clk_sys`: `cpu_phi2` at `tick` 1, `cpu_phi1` at `tick` 3.
- Slow CPU cycle = 48 `clk_sys`: `cpu_phi2` at `tick` 2, `cpu_phi1` at `tick` 5.
- `cpu_phi1`/`cpu_phi2` always coincide with `ce_7`, and are never both high in the same cycle.
- `slow_req` changes outside the latch point have no effect on the current cycle.

## Structure
- Package `a78_clk_pkg`:
  - FAST_TICKS/SLOW_TICKS defaults.
  - `tick` width constant (3 bits).
  - Lock-counter width function ($clog2(LOCK_DELAY+1)).
- Sub-module `a78_sync2`: 2-flop synchronizer with synchronous active-low reset, used for `pll_locked`.

## Test plan
- **Lock release:** `pll_locked`=1, LOCK_DELAY=16 -> `sys_reset_n` rises exactly 19 cycles after `rst_n` release; first `ce_7` 8 cycles later.
- **Divider cadence:** 256 run cycles -> 64 `ce_14` and 32 `ce_7`; every `ce_7` coincides with a `ce_14`.
- **Fast cycles:** `slow_req`=0 -> `cpu_phi1` period 32, `cpu_phi2` 16 cycles after `cpu_phi1`, `cpu_slow`=0.
- **Slow cycle:** `slow_req`=1 at `tick` 0, then dropped -> that cycle is 48 clocks, `cpu_phi2` at `tick` 2, `cpu_slow`=1; the next cycle is 32 clocks.
- **Pause:** `pause` high for 100 clocks spanning a boundary -> no `cpu_phi1`/`cpu_phi2` while high; `ce_7` continues; `cpu_phi1` on the first `ce_7` after `pause` falls.
- **Lock loss:** `pll_locked` dropped mid slow cycle -> `sys_reset_n`=0 after 3 cycles, all enables 0 next cycle; after relock, the full LOCK_DELAY is required again.

Source files
------------

// File: rtl/a78_clk_pkg.sv
// rtl/a78_clk_pkg.sv - shared constants and sizing helpers for the clock-enable sequencer
package a78_clk_pkg;

  localparam int FAST_TICKS_DFLT = 4;
  localparam int SLOW_TICKS_DFLT = 6;
  localparam int TICK_W          = 3;

  function automatic int lock_cnt_w(input int delay);
    return $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/a78_clk_enables_if.sv
// rtl/a78_clk_enables_if.sv - CPU request inputs and enable/reset outputs of the sequencer
interface a78_clk_enables_if;

  logic slow_req;
  logic pause;
  logic sys_reset_n;
  logic ce_14;
  logic ce_7;
  logic cpu_phi1;
  logic cpu_phi2;
  logic cpu_slow;

  modport master (
    input  slow_req,
    input  pause,
    output sys_reset_n,
    output ce_14,
    output ce_7,
    output cpu_phi1,
    output cpu_phi2,
    output cpu_slow
  );

  modport slave (
    output slow_req,
    output pause,
    input  sys_reset_n,
    input  ce_14,
    input  ce_7,
    input  cpu_phi1,
    input  cpu_phi2,
    input  cpu_slow
  );

endinterface

// File: rtl/a78_sync2.sv
// rtl/a78_sync2.sv - two-flop synchronizer with synchronous active-low reset
module a78_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/a78_clk_enables.sv
// rtl/a78_clk_enables.sv - PLL lock sequencing plus 14M/7M/CPU clock-enable generation
module a78_clk_enables
  import a78_clk_pkg::*;
#(
  parameter int LOCK_DELAY = 1024,
  parameter int FAST_TICKS = FAST_TICKS_DFLT,
  parameter int SLOW_TICKS = SLOW_TICKS_DFLT
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  a78_clk_enables_if.master     bus
);

  localparam int                LCW      = lock_cnt_w(LOCK_DELAY);
  localparam logic [LCW-1:0]    LOCK_MAX = LCW'(LOCK_DELAY);
  localparam logic [LCW-1:0]    LCNT_ONE = LCW'(1);
  localparam logic [TICK_W-1:0] FAST_L   = TICK_W'(FAST_TICKS);
  localparam logic [TICK_W-1:0] SLOW_L   = TICK_W'(SLOW_TICKS);
  localparam logic [TICK_W-1:0] T_ONE    = TICK_W'(1);

  logic              lock_s;
  logic [LCW-1:0]    lock_cnt;
  logic              sys_reset_n_q;

  logic [2:0]        div8;
  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] len;
  logic              ce_14_q;
  logic              ce_7_q;
  logic              phi1_q;
  logic              phi2_q;
  logic              cpu_slow_q;

  logic              run;
  logic              ce7_now;
  logic              at_boundary;
  logic              at_mid;

  a78_sync2 u_lock_sync (
    .clk   (clk_sys),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Gating with lock_s lets a lock drop reach sys_reset_n without waiting for lock_cnt to clear.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      lock_cnt      <= '0;
      sys_reset_n_q <= 1'b0;
    end else begin
      if (!lock_s) begin
        lock_cnt <= '0;
      end else if (lock_cnt != LOCK_MAX) begin
        lock_cnt <= lock_cnt + LCNT_ONE;
      end
      sys_reset_n_q <= lock_s && (lock_cnt == LOCK_MAX);
    end
  end

  assign run         = sys_reset_n_q;
  assign ce7_now     = (div8 == 3'd7);
  assign at_boundary = (tick == len - T_ONE);
  assign at_mid      = (tick == (len >> 1) - T_ONE);

  // Every enable is registered from the decode of the current div8/tick state, so all
  // outputs (including cpu_phi*) land on the same clk_sys cycle as the matching ce_7.
  always_ff @(posedge clk_sys) begin
    if (!rst_n || !run) begin
      div8       <= 3'd0;
      tick       <= '0;
      len        <= FAST_L;
      cpu_slow_q <= 1'b0;
      ce_14_q    <= 1'b0;
      ce_7_q     <= 1'b0;
      phi1_q     <= 1'b0;
      phi2_q     <= 1'b0;
    end else begin
      div8    <= div8 + 3'd1;
      ce_14_q <= (div8[1:0] == 2'd3);
      ce_7_q  <= ce7_now;
      phi1_q  <= 1'b0;
      phi2_q  <= 1'b0;
      if (ce7_now) begin
        if (tick == '0) begin
          len        <= bus.slow_req ? SLOW_L : FAST_L;
          cpu_slow_q <= bus.slow_req;
        end
        if (at_boundary) begin
          // A paused CPU parks on the last tick and retries at each following ce_7.
          if (!bus.pause) begin
            phi1_q <= 1'b1;
            tick   <= '0;
          end
        end else begin
          tick   <= tick + T_ONE;
          phi2_q <= at_mid;
        end
      end
    end
  end

  assign bus.sys_reset_n = sys_reset_n_q;
  assign bus.ce_14       = ce_14_q;
  assign bus.ce_7        = ce_7_q;
  assign bus.cpu_phi1    = phi1_q;
  assign bus.cpu_phi2    = phi2_q;
  assign bus.cpu_slow    = cpu_slow_q;

endmodule

// File: tb/tb_a78_clk_enables.sv
// tb/tb_a78_clk_enables.sv - directed self-checking bench for a78_clk_enables
module tb_a78_clk_enables;

  localparam int LD = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic pll_locked;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  a78_clk_enables_if bus ();

  a78_clk_enables #(
    .LOCK_DELAY (LD),
    .FAST_TICKS (4),
    .SLOW_TICKS (6)
  ) dut (
    .clk_sys    (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .bus        (bus.master)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sel(input int code);
    case (code)
      0:       return bus.sys_reset_n;
      1:       return bus.ce_14;
      2:       return bus.ce_7;
      3:       return bus.cpu_phi1;
      4:       return bus.cpu_phi2;
      default: return !bus.sys_reset_n;
    endcase
  endfunction

  function automatic logic [31:0] enables();
    return {27'd0, bus.ce_14, bus.ce_7, bus.cpu_phi1, bus.cpu_phi2, bus.cpu_slow};
  endfunction

  // Returns the number of negedges until the selected signal is seen high, or -1 on timeout.
  task automatic wait_sig(input int code, input int bound, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (sel(code)) break;
      if (n >= bound) begin
        n = -1;
        break;
      end
    end
  endtask

  initial begin
    int n, n2, t0, t_p1, last_p1, prev_p1, last_p2;
    int c14, c7, bad_co, both, slow_cnt, nphi1, nphi2, cphi, cce7, cen;

    rst_n        = 1'b0;
    pll_locked   = 1'b1;
    bus.slow_req = 1'b0;
    bus.pause    = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_sys_reset_n", {31'd0, bus.sys_reset_n}, 0);
    chk("rst_enables", enables(), 0);

    rst_n = 1'b1;
    wait_sig(0, 40, n);
    chk("lock_release", n, 19);
    wait_sig(1, 20, n);
    chk("first_ce_14", n, 4);
    wait_sig(2, 20, n2);
    chk("first_ce_7", n + n2, 8);

    c14 = 0; c7 = 0; bad_co = 0; both = 0; slow_cnt = 0; nphi1 = 0; nphi2 = 0;
    last_p1 = -1; prev_p1 = -1; last_p2 = -1;
    t0 = cyc;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      c14      += int'(bus.ce_14);
      c7       += int'(bus.ce_7);
      slow_cnt += int'(bus.cpu_slow);
      if (bus.ce_7 && !bus.ce_14) bad_co++;
      if ((bus.cpu_phi1 || bus.cpu_phi2) && !bus.ce_7) bad_co++;
      if (bus.cpu_phi1 && bus.cpu_phi2) both++;
      if (bus.cpu_phi1) begin
        prev_p1 = last_p1;
        last_p1 = cyc;
        nphi1++;
      end
      if (bus.cpu_phi2) begin
        last_p2 = cyc;
        nphi2++;
      end
    end
    chk("cadence_ce_14", c14, 64);
    chk("cadence_ce_7", c7, 32);
    chk("coincidence", bad_co, 0);
    chk("phi_overlap", both, 0);
    chk("fast_cpu_slow", slow_cnt, 0);
    chk("fast_phi1_count", nphi1, 8);
    chk("fast_phi2_count", nphi2, 8);
    chk("fast_last_phi1", last_p1 - t0, 248);
    chk("fast_phi1_period", last_p1 - prev_p1, 32);
    chk("fast_phi1_to_phi2", last_p2 - prev_p1, 16);

    bus.slow_req = 1'b1;
    wait_sig(2, 16, n);
    chk("slow_latch_ce7", n, 1);
    chk("slow_cpu_slow_set", {31'd0, bus.cpu_slow}, 1);
    t0 = cyc;
    bus.slow_req = 1'b0;
    wait_sig(4, 40, n);
    chk("slow_phi2_at_tick2", n, 16);
    chk("slow_phi2_on_ce7", {31'd0, bus.ce_7}, 1);
    wait_sig(3, 40, n);
    chk("slow_cycle_len", cyc - last_p1, 48);
    chk("slow_cpu_slow_hold", {31'd0, bus.cpu_slow}, 1);
    t_p1 = cyc;
    wait_sig(3, 40, n);
    chk("after_slow_len", cyc - t_p1, 32);
    chk("after_slow_cpu_slow", {31'd0, bus.cpu_slow}, 0);

    t_p1 = cyc;
    wait_sig(4, 40, n);
    chk("pre_pause_phi2", n, 16);
    bus.pause = 1'b1;
    cphi = 0; cce7 = 0;
    repeat (100) begin
      @(negedge clk);
      cphi += int'(bus.cpu_phi1) + int'(bus.cpu_phi2);
      cce7 += int'(bus.ce_7);
    end
    bus.pause = 1'b0;
    chk("pause_no_phi", cphi, 0);
    chk("pause_ce_7_runs", cce7, 12);
    wait_sig(3, 40, n);
    chk("pause_release_phi1", cyc - t_p1, 120);
    chk("pause_release_on_ce7", {31'd0, bus.ce_7}, 1);

    bus.slow_req = 1'b1;
    wait_sig(2, 16, n);
    chk("loss_slow_latch", n, 8);
    bus.slow_req = 1'b0;
    chk("loss_cpu_slow", {31'd0, bus.cpu_slow}, 1);
    wait_sig(2, 16, n);
    chk("loss_tick1_ce7", n, 8);
    pll_locked = 1'b0;
    wait_sig(5, 10, n);
    chk("loss_reset_delay", n, 3);
    @(negedge clk);
    chk("loss_enables_off", enables(), 0);
    cen = 0;
    repeat (30) begin
      @(negedge clk);
      if (enables() != 0 || bus.sys_reset_n) cen++;
    end
    chk("loss_stay_off", cen, 0);

    pll_locked = 1'b1;
    wait_sig(0, 60, n);
    chk("relock_delay", n, 19);
    wait_sig(2, 20, n);
    chk("relock_first_ce_7", n, 8);
    wait_sig(3, 60, n);
    chk("relock_first_phi1", n, 24);
    chk("relock_cpu_slow", {31'd0, bus.cpu_slow}, 0);

    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_pulse_sys_reset_n", {31'd0, bus.sys_reset_n}, 0);
    chk("rst_pulse_enables", enables(), 0);
    rst_n = 1'b1;
    wait_sig(0, 40, n);
    chk("rst_pulse_release", n, 19);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
